ex_flags_stage: RTL and testbench
=================================

# ex_flags_stage

EX/MEM pipeline stage placed directly downstream of the 8-bit ALU. It registers the ALU result and write-back control for the memory/write-back stages, and it owns the architectural carry and zero flags. The registered carry flag drives the ALU carry input for ADDC/SUBC. The stage supports stall and flush and flags illegal opcodes.

## Interface
- `DW`, default 8: datapath width; must equal the ALU width.
- `RW`, default 3: destination register address width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  EX holds a valid instruction this cycle.
- `in_result`  in  DW  ALU result Y.
- `in_cout`  in  1  ALU carry/borrow/shift-out bit.
- `in_fn`  in  4  ALU function code of the instruction in EX.
- `in_rd`  in  RW  destination register.
- `in_wr_en`  in  1  instruction writes `in_rd`.
- `stall`  in  1  downstream not ready; hold stage.
- `flush`  in  1  squash the instruction in EX.
- `flag_save`  in  1  save-flags pulse (see Configuration).
- `flag_restore`  in  1  restore-flags pulse (see Configuration).
- `out_valid`  out  1  registered valid.
- `out_result`  out  DW  registered result.
- `out_rd`  out  RW  registered destination.
- `out_wr_en`  out  1  registered write enable, qualified by valid.
- `flag_c`  out  1  carry flag; also the ALU Cin.
- `flag_z`  out  1  zero flag.
- `illegal`  out  1  sticky illegal-opcode indicator.

## Operation
- Capture condition: `cap = in_valid & ~stall & ~flush`.
- When `cap` is set, the next rising edge loads `out_result`, `out_rd` and `out_valid=1`. It also loads `out_wr_en = in_wr_en & legal`.
- `legal` means `in_fn` is in the range 0000–1011.
- Flag update applies only when `cap` is set:
  - fn 0000–0011 (ADD/ADDC/SUB/SUBC): C←`in_cout`, Z←(`in_result`==0).
  - fn 0100–0111 (AND/OR/XOR/MASK): Z←(`in_result`==0); C is unchanged.
  - fn 1000–1011 (shifts/rotates): C←`in_cout`, Z←(`in_result`==0).
  - fn 1100–1111: flags are unchanged, `out_wr_en`=0, `out_valid`=1, and `illegal` sets.
- Z is always recomputed from `in_result` across the full DW bits. No ALU zero output is consumed.
- `illegal` stays set until reset.
- When `~stall & ~cap` (a bubble or a flush), `out_valid` and `out_wr_en` clear. `out_result` and `out_rd` hold.
- When `stall` is set and `flush` is clear, all registers hold, including the flags.
- `flush` overrides `stall` and `in_valid`. The squashed instruction never updates the flags.

## Timing
- Latency is 1 cycle from EX inputs to `out_*`.
- A flag update is visible on `flag_c` in the next cycle. A back-to-back ADD then ADDC therefore sees the new carry without forwarding.
- Reset values: `out_valid`=0, `out_result`=0, `out_rd`=0, `out_wr_en`=0, `flag_c`=0, `flag_z`=0, `illegal`=0, shadow flags=0.
- Reset asserted mid-operation clears everything immediately, independent of `clk`.
- The first capture happens on the first rising edge after `rst_n` deasserts.
- `flag_c` and `flag_z` are direct register outputs. There is no combinational path from any input to any output.

## Configuration
- `FLAG_SHADOW_EN` defined:
  - A 2-bit shadow register {C,Z} is present.
  - `flag_save` copies the current flags into the shadow at the edge.
  - `flag_restore` loads the shadow into the flags. Restore wins over a same-cycle flag update.
  - Save and restore in the same cycle swap the flags and the shadow.
  - Stall does not block save or restore.
- `FLAG_SHADOW_EN` undefined:
  - No shadow register is built.
  - `flag_save` and `flag_restore` are ignored; the ports remain so the interface is fixed.

## Test plan
- Reset, then ADD with `in_result`=8'h00, `in_cout`=1, `in_wr_en`=1 → next cycle `flag_c`=1, `flag_z`=1, `out_valid`=1, `out_wr_en`=1.
- AND with `in_result`=8'h5A, `in_cout`=0 while `flag_c`=1 → `flag_z`=0, `flag_c` stays 1.
- Valid ADD with `stall`=1 for 3 cycles → outputs and flags hold. On release, capture occurs one cycle later.
- `flush`=1 and `stall`=1 with a valid SUB → `out_valid`=0 next cycle, flags unchanged.
- `in_fn`=4'b1110 with `in_wr_en`=1 → `out_wr_en`=0, `illegal`=1, which persists until `rst_n` is low.
- With `FLAG_SHADOW_EN`: flags {1,0}, save, then an ADD producing {0,1}, then restore → flags {1,0}. Without the macro, the same stimulus leaves flags {0,1}.

Source files
------------

// File: rtl/ex_flags_stage.sv
// EX/MEM stage after the 8-bit ALU: registers result/write-back control and owns the C/Z flags.
// Define FLAG_SHADOW_EN to build the {C,Z} shadow register driven by flag_save/flag_restore.
module ex_flags_stage #(
  parameter int DW = 8,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_result,
  input  logic          in_cout,
  input  logic [3:0]    in_fn,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wr_en,
  input  logic          stall,
  input  logic          flush,
  input  logic          flag_save,
  input  logic          flag_restore,
  output logic          out_valid,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_wr_en,
  output logic          flag_c,
  output logic          flag_z,
  output logic          illegal
);

  function automatic logic is_zero(input logic [DW-1:0] v);
    return (v == '0);
  endfunction

  function automatic logic fn_legal(input logic [3:0] fn);
    return ~(fn[3] & fn[2]);
  endfunction

  // Logic ops (01xx) leave carry alone; arithmetic and shifts update it.
  function automatic logic fn_sets_c(input logic [3:0] fn);
    return (fn[3:2] != 2'b01);
  endfunction

  logic cap;
  logic legal;
  logic bubble;
  logic upd_z;
  logic upd_c;

  assign cap    = in_valid & ~stall & ~flush;
  assign legal  = fn_legal(in_fn);
  assign bubble = (~stall | flush) & ~cap;
  assign upd_z  = cap & legal;
  assign upd_c  = upd_z & fn_sets_c(in_fn);

  // EX -> MEM boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_wr_en  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if (cap) begin
        out_valid  <= 1'b1;
        out_result <= in_result;
        out_rd     <= in_rd;
        out_wr_en  <= in_wr_en & legal;
        if (!legal) illegal <= 1'b1;
      end else if (bubble) begin
        out_valid <= 1'b0;
        out_wr_en <= 1'b0;
      end
    end
  end

`ifdef FLAG_SHADOW_EN
  logic shadow_c;
  logic shadow_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      shadow_c <= 1'b0;
      shadow_z <= 1'b0;
    end else begin
      if (flag_save) begin
        shadow_c <= flag_c;
        shadow_z <= flag_z;
      end
      // Restore takes priority over an instruction's flag update in the same cycle.
      if (flag_restore) begin
        flag_c <= shadow_c;
        flag_z <= shadow_z;
      end else begin
        if (upd_c) flag_c <= in_cout;
        if (upd_z) flag_z <= is_zero(in_result);
      end
    end
  end
`else
  logic unused_shadow_ctl;
  assign unused_shadow_ctl = flag_save ^ flag_restore;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (upd_c) flag_c <= in_cout;
      if (upd_z) flag_z <= is_zero(in_result);
    end
  end
`endif

endmodule

// File: tb/tb_ex_flags_stage.sv
// Directed bench for ex_flags_stage: capture, flags, stall/flush, illegal, shadow and async reset.
`timescale 1ns/1ps
module tb_ex_flags_stage;
  localparam int DW = 8;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_result;
  logic          in_cout;
  logic [3:0]    in_fn;
  logic [RW-1:0] in_rd;
  logic          in_wr_en;
  logic          stall;
  logic          flush;
  logic          flag_save;
  logic          flag_restore;
  logic          out_valid;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_rd;
  logic          out_wr_en;
  logic          flag_c;
  logic          flag_z;
  logic          illegal;

  int n_tests = 0;
  int n_fail  = 0;

  ex_flags_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_result(in_result), .in_cout(in_cout),
    .in_fn(in_fn), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .stall(stall), .flush(flush),
    .flag_save(flag_save), .flag_restore(flag_restore),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .flag_c(flag_c), .flag_z(flag_z), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] fn, input logic [DW-1:0] res,
                       input logic co, input logic [RW-1:0] rd, input logic we);
    in_valid = v; in_fn = fn; in_result = res; in_cout = co; in_rd = rd; in_wr_en = we;
  endtask

  task automatic check_flags(input string tag, input logic c, input logic z);
    check({tag, ".c"}, {31'd0, flag_c}, {31'd0, c});
    check({tag, ".z"}, {31'd0, flag_z}, {31'd0, z});
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, ".valid"},  {31'd0, out_valid}, 32'd0);
    check({tag, ".result"}, {24'd0, out_result}, 32'd0);
    check({tag, ".rd"},     {29'd0, out_rd}, 32'd0);
    check({tag, ".wr_en"},  {31'd0, out_wr_en}, 32'd0);
    check({tag, ".illegal"},{31'd0, illegal}, 32'd0);
    check_flags(tag, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flag_save = 1'b0; flag_restore = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b0);
    #2;
    check_zero_state("reset");
    tick(); tick();
    rst_n = 1'b1;

    // ADD 0 with carry out
    drive(1'b1, 4'h0, 8'h00, 1'b1, 3'd5, 1'b1);
    tick();
    check("add.valid", {31'd0, out_valid}, 32'd1);
    check("add.wr_en", {31'd0, out_wr_en}, 32'd1);
    check("add.rd", {29'd0, out_rd}, 32'd5);
    check_flags("add", 1'b1, 1'b1);

    // AND keeps carry
    drive(1'b1, 4'h4, 8'h5A, 1'b0, 3'd2, 1'b1);
    tick();
    check("and.result", {24'd0, out_result}, 32'h5A);
    check_flags("and", 1'b1, 1'b0);

    // stalled ADD holds everything for 3 cycles
    drive(1'b1, 4'h0, 8'h80, 1'b0, 3'd3, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.result", {24'd0, out_result}, 32'h5A);
      check("stall.rd", {29'd0, out_rd}, 32'd2);
      check("stall.valid", {31'd0, out_valid}, 32'd1);
      check_flags("stall", 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick();
    check("release.result", {24'd0, out_result}, 32'h80);
    check("release.rd", {29'd0, out_rd}, 32'd3);
    check_flags("release", 1'b0, 1'b0);

    // bubble clears valid/wr_en, holds data
    drive(1'b0, 4'h0, 8'h00, 1'b1, 3'd7, 1'b1);
    tick();
    check("bubble.valid", {31'd0, out_valid}, 32'd0);
    check("bubble.wr_en", {31'd0, out_wr_en}, 32'd0);
    check("bubble.result", {24'd0, out_result}, 32'h80);
    check_flags("bubble", 1'b0, 1'b0);

    // ADDC then flushed+stalled SUB
    drive(1'b1, 4'h1, 8'h01, 1'b1, 3'd4, 1'b1);
    tick();
    check_flags("addc", 1'b1, 1'b0);
    drive(1'b1, 4'h2, 8'h00, 1'b0, 3'd1, 1'b1);
    stall = 1'b1; flush = 1'b1;
    tick();
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    check("flush.wr_en", {31'd0, out_wr_en}, 32'd0);
    check("flush.result", {24'd0, out_result}, 32'h01);
    check_flags("flush", 1'b1, 1'b0);
    stall = 1'b0; flush = 1'b0;

    // illegal opcode
    drive(1'b1, 4'hE, 8'h00, 1'b0, 3'd6, 1'b1);
    tick();
    check("ill.valid", {31'd0, out_valid}, 32'd1);
    check("ill.wr_en", {31'd0, out_wr_en}, 32'd0);
    check("ill.rd", {29'd0, out_rd}, 32'd6);
    check("ill.flag", {31'd0, illegal}, 32'd1);
    check_flags("ill", 1'b1, 1'b0);
    drive(1'b1, 4'h6, 8'h00, 1'b0, 3'd1, 1'b1);
    tick();
    check("ill.sticky", {31'd0, illegal}, 32'd1);
    check("xor.wr_en", {31'd0, out_wr_en}, 32'd1);
    check_flags("xor", 1'b1, 1'b1);

    // shift: C from cout, Z from result
    drive(1'b1, 4'h9, 8'h40, 1'b0, 3'd1, 1'b1);
    tick();
    check_flags("shift", 1'b0, 1'b0);

    // shadow save/restore
    drive(1'b1, 4'h0, 8'h03, 1'b1, 3'd1, 1'b1);
    tick();
    check_flags("pre_save", 1'b1, 1'b0);
    drive(1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b0);
    flag_save = 1'b1;
    tick();
    flag_save = 1'b0;
    check_flags("save", 1'b1, 1'b0);
    drive(1'b1, 4'h0, 8'h00, 1'b0, 3'd1, 1'b1);
    tick();
    check_flags("post_add", 1'b0, 1'b1);
    drive(1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b0);
    flag_restore = 1'b1;
    tick();
    flag_restore = 1'b0;
`ifdef FLAG_SHADOW_EN
    check_flags("restore", 1'b1, 1'b0);
`else
    check_flags("restore", 1'b0, 1'b1);
`endif

    // async reset mid-cycle, then first capture right after release
    drive(1'b1, 4'hF, 8'h11, 1'b1, 3'd2, 1'b1);
    tick();
    check("pre_rst.valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_state("async_rst");
    tick();
    rst_n = 1'b1;
    drive(1'b1, 4'h0, 8'h00, 1'b1, 3'd7, 1'b1);
    tick();
    check("first.valid", {31'd0, out_valid}, 32'd1);
    check("first.rd", {29'd0, out_rd}, 32'd7);
    check_flags("first", 1'b1, 1'b1);
    check("first.illegal", {31'd0, illegal}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
